// File: rtl/serial_compare_ctrl.sv
// rtl/serial_compare_ctrl.sv - MSB-first 2-bit-per-cycle unsigned magnitude comparator sequencer
// Reports gt/eq/lt with a one-cycle done pulse and stops at the first unequal bit pair.
module serial_compare_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             gt,
    output logic             eq,
    output logic             lt
);
    localparam int PAIRS = WIDTH / 2;
    localparam int CW    = $clog2(PAIRS) + 1;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t          state;
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic [CW-1:0]    cnt;
    logic [1:0]       pa;
    logic [1:0]       pb;
    logic             g_ab;
    logic             g_ba;

    // The same 2-bit greater cell is used in both directions, with operands swapped.
    function automatic logic greater2(input logic [1:0] x, input logic [1:0] y);
        return (x[1] & ~y[1]) | (~(x[1] ^ y[1]) & x[0] & ~y[0]);
    endfunction

    assign pa   = sa[WIDTH-1:WIDTH-2];
    assign pb   = sb[WIDTH-1:WIDTH-2];
    assign g_ab = greater2(pa, pb);
    assign g_ba = greater2(pb, pa);
    assign busy = (state == RUN);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            sa    <= '0;
            sb    <= '0;
            cnt   <= '0;
            done  <= 1'b0;
            gt    <= 1'b0;
            eq    <= 1'b0;
            lt    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        sa    <= a;
                        sb    <= b;
                        cnt   <= CW'(PAIRS - 1);
                        gt    <= 1'b0;
                        eq    <= 1'b0;
                        lt    <= 1'b0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (g_ab) begin
                        gt    <= 1'b1;
                        done  <= 1'b1;
                        state <= IDLE;
                    end else if (g_ba) begin
                        lt    <= 1'b1;
                        done  <= 1'b1;
                        state <= IDLE;
                    end else if (cnt != '0) begin
                        sa  <= sa << 2;
                        sb  <= sb << 2;
                        cnt <= cnt - 1'b1;
                    end else begin
                        eq    <= 1'b1;
                        done  <= 1'b1;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_serial_compare_ctrl.sv
// tb/tb_serial_compare_ctrl.sv - directed and sampled-sweep bench for serial_compare_ctrl
module tb_serial_compare_ctrl;
    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic       busy;
    logic       done;
    logic       gt;
    logic       eq;
    logic       lt;

    int total = 0;
    int bad   = 0;

    serial_compare_ctrl #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .gt    (gt),
        .eq    (eq),
        .lt    (lt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Launch one comparison; returns cycles from accept edge to done, plus flags seen.
    task automatic do_cmp(input logic [7:0] ta, input logic [7:0] tb_v, output int lat,
                          output logic busy1, output logic [2:0] f1, output logic [2:0] res);
        @(negedge clk);
        a = ta; b = tb_v; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        busy1 = busy;
        f1    = {gt, eq, lt};
        lat   = 0;
        while (!done && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        res = {gt, eq, lt};
    endtask

    function automatic int ref_lat(input logic [7:0] x, input logic [7:0] y);
        for (int p = 3; p >= 0; p--)
            if (x[2*p +: 2] != y[2*p +: 2]) return 4 - p;
        return 4;
    endfunction

    function automatic logic [2:0] ref_res(input logic [7:0] x, input logic [7:0] y);
        if (x > y) return 3'b100;
        if (x == y) return 3'b010;
        return 3'b001;
    endfunction

    initial begin
        int         lat;
        logic       busy1;
        logic [2:0] f1;
        logic [2:0] res;
        int         ndone;
        int         nlt;
        int         dup;
        logic       prev_done;

        rst = 1'b1; start = 1'b0; a = '0; b = '0;
        repeat (2) @(negedge clk);
        chk("reset_outputs", {27'd0, busy, done, gt, eq, lt}, 32'h0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_after_reset", {27'd0, busy, done, gt, eq, lt}, 32'h0);

        do_cmp(8'hB4, 8'h74, lat, busy1, f1, res);
        chk("t1_busy", {31'd0, busy1}, 32'd1);
        chk("t1_flags_cleared", {29'd0, f1}, 32'd0);
        chk("t1_lat", lat, 32'd1);
        chk("t1_res", {29'd0, res}, 32'b100);

        do_cmp(8'h55, 8'h55, lat, busy1, f1, res);
        chk("t2_lat", lat, 32'd4);
        chk("t2_res", {29'd0, res}, 32'b010);
        @(negedge clk);
        chk("t2_hold", {27'd0, busy, done, gt, eq, lt}, 32'b00010);

        do_cmp(8'h12, 8'h13, lat, busy1, f1, res);
        chk("t3a_lat", lat, 32'd4);
        chk("t3a_res", {29'd0, res}, 32'b001);
        do_cmp(8'h1C, 8'h18, lat, busy1, f1, res);
        chk("t3b_lat", lat, 32'd3);
        chk("t3b_res", {29'd0, res}, 32'b100);

        @(negedge clk);
        a = 8'h00; b = 8'hFF; start = 1'b1;
        @(negedge clk);
        a = 8'hFF; b = 8'h00;
        @(negedge clk);
        start = 1'b0;
        chk("t4_done", {31'd0, done}, 32'd1);
        chk("t4_res", {29'd0, gt, eq, lt}, 32'b001);
        @(negedge clk);
        chk("t4_no_restart", {30'd0, busy, done}, 32'd0);

        a = 8'hAA; b = 8'hAA; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        chk("t5_busy_before_rst", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        #1;
        chk("t5_async_clear", {27'd0, busy, done, gt, eq, lt}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        chk("t5_stays_idle", {27'd0, busy, done, gt, eq, lt}, 32'h0);

        a = 8'h01; b = 8'h02; start = 1'b1;
        ndone = 0; nlt = 0; dup = 0; prev_done = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done) begin
                ndone++;
                if ({gt, eq, lt} == 3'b001) nlt++;
                if (prev_done) dup++;
            end
            prev_done = done;
        end
        start = 1'b0;
        chk("t6_done_count", ndone, 32'd4);
        chk("t6_lt_count", nlt, 32'd4);
        chk("t6_no_double_done", dup, 32'd0);
        repeat (6) @(negedge clk);

        for (int x = 0; x < 256; x += 3) begin
            for (int y = 0; y < 256; y += 17) begin
                do_cmp(8'(x), 8'(y), lat, busy1, f1, res);
                chk($sformatf("sweep_lat_%0h_%0h", x, y), lat, ref_lat(8'(x), 8'(y)));
                chk($sformatf("sweep_res_%0h_%0h", x, y), {29'd0, res}, {29'd0, ref_res(8'(x), 8'(y))});
            end
            do_cmp(8'(x), 8'(x), lat, busy1, f1, res);
            chk($sformatf("sweep_eq_%0h", x), {28'd0, lat[3:0]} , 32'd4);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
